// File: rtl/dma_periph_pkg.sv
// Shared types and constants for the DMA peripheral responder and later channel models.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dma_periph_pkg;

    // One-hot encoding, matching the DMA controller's state style.
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_REQ     = 5'b00010,
        ST_XFER    = 5'b00100,
        ST_RELEASE = 5'b01000,
        ST_DONE    = 5'b10000
    } state_t;

    localparam logic DIR_SOURCE = 1'b0;  // device -> memory, serviced by IOR_N
    localparam logic DIR_SINK   = 1'b1;  // memory -> device, serviced by IOW_N

    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count.
// Latency: push visible at pop_dat one cycle after the write edge; pop_dat is the head, read combinationally.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop is ignored when empty.
//
// Ports: core_clk/arst_n (async active-low reset), push/push_dat, pop/pop_dat (head),
//        full, empty, count (0..DEPTH). DEPTH must be a power of two >= 2.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     core_clk,
    input  logic                     arst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign pop_dat = mem[rd_ptr];

    // Storage is not reset: the pointers alone define what is valid.
    always_ff @(posedge core_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_peripheral_responder.sv
// Single-channel DMA peripheral endpoint: DREQ/DACK handshake, one byte per IOR_N/IOW_N strobe, stops on EOP_N.
// Latency: DREQ rises one edge after the FIFO threshold is met in IDLE; a strobe moves data at the edge ending its first low cycle.
// Backpressure: local side is valid/ready on an internal FIFO (s_ready = not full, m_valid = not empty); bus side waits via DREQ.
//
// Ports: CLK, RESET_N (async, active-low); enable, dir (sampled in IDLE); bus side DREQ, DACK, IOR_N, IOW_N,
//        EOP_N, DB_IN, DB_OUT, DB_OE; local stream s_valid/s_data/s_ready (source) and m_valid/m_data/m_ready
//        (sink); status xfer_count, done, dir_err; clear (sync clear of status, FSM back to IDLE).
// Build option: define DMA_PERIPH_DEMAND_EN for demand mode (DREQ held across transfers while the threshold holds).
module dma_peripheral_responder
    import dma_periph_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8,
    parameter int REQ_THRESH = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  enable,
    input  logic                  dir,
    output logic                  DREQ,
    input  logic                  DACK,
    input  logic                  IOR_N,
    input  logic                  IOW_N,
    input  logic                  EOP_N,
    input  logic [DATA_W-1:0]     DB_IN,
    output logic [DATA_W-1:0]     DB_OUT,
    output logic                  DB_OE,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_W-1:0]     m_data,
    input  logic                  m_ready,
    output logic [XFER_CNT_W-1:0] xfer_count,
    output logic                  done,
    output logic                  dir_err,
    input  logic                  clear
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] THRESH  = CW'(REQ_THRESH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    state_t            state;
    logic              dir_q;
    logic              armed;
    logic [CW-1:0]     occ;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;

    logic cur_dir, src, in_xfer;
    logic ior_low, iow_low, good_strobe, bad_strobe;
    logic strobe_ok, fifo_blocked, bus_xfer, set_err, eop;
    logic loc_push, loc_pop, fifo_push, fifo_pop;
    logic [DATA_W-1:0] fifo_din;

    // Source needs data to send, sink needs room to receive.
    function automatic logic thresh_met(input logic d, input logic [CW-1:0] n);
        return (d == DIR_SOURCE) ? (n >= THRESH) : ((DEPTH_C - n) >= THRESH);
    endfunction

    // dir is only taken from the pin while idle; afterwards the latched copy rules.
    assign cur_dir = (state == ST_IDLE) ? dir : dir_q;
    assign src     = (cur_dir == DIR_SOURCE);
    assign in_xfer = (state == ST_XFER);

    assign ior_low     = ~IOR_N;
    assign iow_low     = ~IOW_N;
    assign good_strobe = src ? ior_low : iow_low;
    assign bad_strobe  = src ? iow_low : ior_low;

    // armed makes a strobe held low for several cycles count once.
    assign strobe_ok    = in_xfer & DACK & good_strobe & armed;
    assign fifo_blocked = src ? empty : full;
    assign bus_xfer     = strobe_ok & ~fifo_blocked;
    assign set_err      = (DACK & bad_strobe) | (strobe_ok & fifo_blocked);
    assign eop          = DACK & ~EOP_N;

    assign s_ready   = src & ~full;
    assign m_valid   = ~src & ~empty;
    assign m_data    = head;
    assign loc_push  = s_valid & s_ready;
    assign loc_pop   = m_valid & m_ready;
    assign fifo_push = src ? loc_push : bus_xfer;
    assign fifo_pop  = src ? bus_xfer : loc_pop;
    assign fifo_din  = src ? s_data : DB_IN;

    assign DB_OE  = in_xfer & src & DACK & ior_low;
    assign DB_OUT = (in_xfer && src) ? head : '0;

`ifdef DMA_PERIPH_DEMAND_EN
    // Occupancy as it will be after this edge, including any local traffic.
    logic [CW-1:0] occ_next;
    always_comb begin
        occ_next = occ;
        if (fifo_push && !fifo_pop) begin
            occ_next = occ + 1'b1;
        end else if (!fifo_push && fifo_pop) begin
            occ_next = occ - 1'b1;
        end
    end
`endif

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .core_clk (CLK),
        .arst_n   (RESET_N),
        .push     (fifo_push),
        .push_dat (fifo_din),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .count    (occ)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            DREQ       <= 1'b0;
            done       <= 1'b0;
            dir_err    <= 1'b0;
            xfer_count <= '0;
            dir_q      <= DIR_SOURCE;
            armed      <= 1'b1;
        end else if (clear) begin
            state      <= ST_IDLE;
            DREQ       <= 1'b0;
            done       <= 1'b0;
            dir_err    <= 1'b0;
            xfer_count <= '0;
            armed      <= 1'b1;
        end else begin
            if (set_err)  dir_err    <= 1'b1;
            if (bus_xfer) xfer_count <= xfer_count + 1'b1;

            if (bus_xfer) begin
                armed <= 1'b0;
            end else if (!in_xfer || !good_strobe) begin
                armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    dir_q <= dir;
                    if (enable && !done && thresh_met(dir, occ)) begin
                        state <= ST_REQ;
                        DREQ  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (DACK) begin
                        state <= ST_XFER;
                    end else if (!enable) begin
                        state <= ST_IDLE;
                        DREQ  <= 1'b0;
                    end
                end
                ST_XFER: begin
                    // A strobe in the EOP cycle still moves its data above.
                    if (eop) begin
                        state <= ST_DONE;
                        DREQ  <= 1'b0;
                        done  <= 1'b1;
                    end else if (bus_xfer) begin
`ifdef DMA_PERIPH_DEMAND_EN
                        if (!thresh_met(dir_q, occ_next)) begin
                            state <= ST_RELEASE;
                            DREQ  <= 1'b0;
                        end
`else
                        state <= ST_RELEASE;
                        DREQ  <= 1'b0;
`endif
                    end
                end
                ST_RELEASE: begin
                    if (eop) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (!DACK) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                    DREQ  <= 1'b0;
                end
            endcase
        end
    end

endmodule
